// File: rtl/traffic_pkg.sv
// traffic_pkg: light encodings, fault codes and monitor modes shared by the monitor blocks.
// Rev 1.0
`default_nettype none

package traffic_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  typedef enum logic [2:0] {
    FC_NONE         = 3'd0,
    FC_ILLEGAL_ENC  = 3'd1,
    FC_CONFLICT     = 3'd2,
    FC_BAD_SEQ      = 3'd3,
    FC_SHORT_GREEN  = 3'd4,
    FC_SHORT_YELLOW = 3'd5
  } fault_code_e;

  typedef enum logic [0:0] {
    MODE_RUN   = 1'b0,
    MODE_FAULT = 1'b1
  } mode_e;

  function automatic logic is_legal(input logic [2:0] st);
    return (st == LIGHT_RED) || (st == LIGHT_YELLOW) || (st == LIGHT_GREEN);
  endfunction

  function automatic logic is_legal_step(input logic [2:0] prev, input logic [2:0] nxt);
    return ((prev == LIGHT_GREEN)  && (nxt == LIGHT_YELLOW)) ||
           ((prev == LIGHT_YELLOW) && (nxt == LIGHT_RED))    ||
           ((prev == LIGHT_RED)    && (nxt == LIGHT_GREEN));
  endfunction

endpackage

`default_nettype wire

// File: rtl/light_dwell_tracker.sv
// light_dwell_tracker: remembers one direction's last light state and how long it has been held.
// Rev 1.0
`default_nettype none

module light_dwell_tracker
  import traffic_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [2:0]    st_i,
  input  logic          clr_i,
  output logic [2:0]    prev_st_o,
  output logic [CW-1:0] dwell_o,
  output logic          changed_o
);

  logic [2:0]    prev_st_q, prev_st_d;
  logic [CW-1:0] dwell_q, dwell_d;
  logic          prev_valid_q, prev_valid_d;
  logic          changed;

  assign changed = prev_valid_q && (st_i != prev_st_q);

  always_comb begin
    prev_st_d    = st_i;
    prev_valid_d = !clr_i;
    if (!prev_valid_q || changed) begin
      dwell_d = CW'(1);
    end else if (dwell_q != '1) begin
      dwell_d = dwell_q + CW'(1);
    end else begin
      dwell_d = dwell_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_st_q    <= LIGHT_RED;
      dwell_q      <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      prev_st_q    <= prev_st_d;
      dwell_q      <= dwell_d;
      prev_valid_q <= prev_valid_d;
    end
  end

  assign prev_st_o = prev_st_q;
  assign dwell_o   = dwell_q;
  assign changed_o = changed;

endmodule

`default_nettype wire

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: drives the lamps from the controller states and latches the first rule violation.
// Rev 1.0
`default_nettype none

module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN  = 4,
  parameter int MIN_YELLOW = 2,
  parameter int BLINK_HALF = 2,
  parameter int CW         = 8
) (
  input  logic       iClk,
  input  logic       iRstN,
  input  logic [2:0] iMainSt,
  input  logic [2:0] iCrossSt,
  input  logic       iClrFault,
  output logic [2:0] oMainLamp,
  output logic [2:0] oCrossLamp,
  output logic       oFault,
  output logic [2:0] oFaultCode
);

  localparam int            BW         = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [CW-1:0] MIN_G_CNT  = CW'(MIN_GREEN);
  localparam logic [CW-1:0] MIN_Y_CNT  = CW'(MIN_YELLOW);

  mode_e         mode_q;
  fault_code_e   code_q;
  logic          fault_q;
  logic          blink_q;
  logic [BW-1:0] blink_cnt_q;
  logic [2:0]    main_lamp_q, cross_lamp_q;

  logic [2:0]    main_prev, cross_prev;
  logic [CW-1:0] main_dwell, cross_dwell;
  logic          main_chg, cross_chg;
  logic          trk_clr;
  fault_code_e   main_v, cross_v, viol_code;

  // Forgetting history on a clear lets the first sample afterwards be any legal colour.
  assign trk_clr = (mode_q == MODE_FAULT) && iClrFault;

  light_dwell_tracker #(.CW(CW)) u_main_trk (
    .clk_i     (iClk),
    .rst_ni    (iRstN),
    .st_i      (iMainSt),
    .clr_i     (trk_clr),
    .prev_st_o (main_prev),
    .dwell_o   (main_dwell),
    .changed_o (main_chg)
  );

  light_dwell_tracker #(.CW(CW)) u_cross_trk (
    .clk_i     (iClk),
    .rst_ni    (iRstN),
    .st_i      (iCrossSt),
    .clr_i     (trk_clr),
    .prev_st_o (cross_prev),
    .dwell_o   (cross_dwell),
    .changed_o (cross_chg)
  );

  function automatic fault_code_e dir_viol(input logic [2:0] prev, input logic [2:0] cur,
                                           input logic [CW-1:0] dwell, input logic chg);
    dir_viol = FC_NONE;
    if (chg) begin
      if (!is_legal_step(prev, cur)) begin
        dir_viol = FC_BAD_SEQ;
      end else if ((prev == LIGHT_GREEN) && (dwell < MIN_G_CNT)) begin
        dir_viol = FC_SHORT_GREEN;
      end else if ((prev == LIGHT_YELLOW) && (dwell < MIN_Y_CNT)) begin
        dir_viol = FC_SHORT_YELLOW;
      end
    end
  endfunction

  always_comb begin
    main_v  = dir_viol(main_prev, iMainSt, main_dwell, main_chg);
    cross_v = dir_viol(cross_prev, iCrossSt, cross_dwell, cross_chg);
    if (!is_legal(iMainSt) || !is_legal(iCrossSt)) begin
      viol_code = FC_ILLEGAL_ENC;
    end else if ((iMainSt != LIGHT_RED) && (iCrossSt != LIGHT_RED)) begin
      viol_code = FC_CONFLICT;
    end else if (main_v == FC_NONE) begin
      viol_code = cross_v;
    end else if (cross_v == FC_NONE) begin
      viol_code = main_v;
    end else begin
      viol_code = (main_v < cross_v) ? main_v : cross_v;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      mode_q       <= MODE_RUN;
      fault_q      <= 1'b0;
      code_q       <= FC_NONE;
      blink_q      <= 1'b1;
      blink_cnt_q  <= '0;
      main_lamp_q  <= LIGHT_RED;
      cross_lamp_q <= LIGHT_RED;
    end else begin
      case (mode_q)
        MODE_RUN: begin
          // The violating sample itself is still forwarded; the override starts a cycle later.
          main_lamp_q  <= iMainSt;
          cross_lamp_q <= iCrossSt;
          if (viol_code != FC_NONE) begin
            mode_q      <= MODE_FAULT;
            fault_q     <= 1'b1;
            code_q      <= viol_code;
            blink_q     <= 1'b1;
            blink_cnt_q <= '0;
          end
        end
        MODE_FAULT: begin
          if (iClrFault) begin
            mode_q       <= MODE_RUN;
            fault_q      <= 1'b0;
            code_q       <= FC_NONE;
            blink_q      <= 1'b1;
            blink_cnt_q  <= '0;
            main_lamp_q  <= iMainSt;
            cross_lamp_q <= iCrossSt;
          end else begin
            main_lamp_q  <= {blink_q, 2'b00};
            cross_lamp_q <= {blink_q, 2'b00};
            if (blink_cnt_q == BLINK_LAST) begin
              blink_cnt_q <= '0;
              blink_q     <= ~blink_q;
            end else begin
              blink_cnt_q <= blink_cnt_q + BW'(1);
            end
          end
        end
        default: mode_q <= MODE_RUN;
      endcase
    end
  end

  assign oMainLamp  = main_lamp_q;
  assign oCrossLamp = cross_lamp_q;
  assign oFault     = fault_q;
  assign oFaultCode = code_q;

endmodule

`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed scenarios then random light sequences against a history-based model.
// Rev 1.0
`default_nettype none

module tb_traffic_light_monitor;

  localparam int MIN_GREEN  = 4;
  localparam int MIN_YELLOW = 2;
  localparam int BLINK_HALF = 2;
  localparam int CW         = 8;
  localparam int R = 4, Y = 2, G = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] main_st = 3'd4;
  logic [2:0] cross_st = 3'd4;
  logic       clr = 1'b0;
  logic [2:0] main_lamp, cross_lamp, fault_code;
  logic       fault;

  int checks = 0;
  int errors = 0;

  bit         m_fault;
  int         m_code;
  int         m_k;
  logic [2:0] m_ml, m_cl;
  int         hist_m[$];
  int         hist_c[$];

  always #5 clk = ~clk;

  traffic_light_monitor #(
    .MIN_GREEN (MIN_GREEN),
    .MIN_YELLOW(MIN_YELLOW),
    .BLINK_HALF(BLINK_HALF),
    .CW        (CW)
  ) dut (
    .iClk      (clk),
    .iRstN     (rst_n),
    .iMainSt   (main_st),
    .iCrossSt  (cross_st),
    .iClrFault (clr),
    .oMainLamp (main_lamp),
    .oCrossLamp(cross_lamp),
    .oFault    (fault),
    .oFaultCode(fault_code)
  );

  function automatic bit legal(input int x);
    return (x == R) || (x == Y) || (x == G);
  endfunction

  // Violation for one direction, judged from the list of samples seen since reset/clear.
  function automatic int dir_viol(input int x, input bit sel);
    int q[$];
    int prev, run;
    q = sel ? hist_c : hist_m;
    if (q.size() == 0) return 0;
    prev = q[q.size()-1];
    if (x == prev) return 0;
    if (!((prev == G && x == Y) || (prev == Y && x == R) || (prev == R && x == G))) return 3;
    run = 0;
    for (int i = q.size() - 1; i >= 0 && q[i] == prev; i--) run++;
    if (run > 255) run = 255;
    if (prev == G && run < MIN_GREEN) return 4;
    if (prev == Y && run < MIN_YELLOW) return 5;
    return 0;
  endfunction

  function automatic int expected_code(input int m, input int c);
    int vm, vc;
    if (!legal(m) || !legal(c)) return 1;
    if (m != R && c != R) return 2;
    vm = dir_viol(m, 1'b0);
    vc = dir_viol(c, 1'b1);
    if (vm == 0) return vc;
    if (vc == 0) return vm;
    return (vm < vc) ? vm : vc;
  endfunction

  function automatic void push_hist(input int m, input int c);
    hist_m.push_back(m);
    hist_c.push_back(c);
    if (hist_m.size() > 300) void'(hist_m.pop_front());
    if (hist_c.size() > 300) void'(hist_c.pop_front());
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".main_lamp"}, {5'd0, main_lamp}, {5'd0, m_ml});
    chk({tag, ".cross_lamp"}, {5'd0, cross_lamp}, {5'd0, m_cl});
    chk({tag, ".fault"}, {7'd0, fault}, {7'd0, m_fault});
    chk({tag, ".code"}, {5'd0, fault_code}, 8'(m_code));
  endtask

  function automatic void model_reset();
    m_fault = 1'b0;
    m_code  = 0;
    m_k     = 0;
    m_ml    = 3'd4;
    m_cl    = 3'd4;
    hist_m.delete();
    hist_c.delete();
  endfunction

  // Called at a falling edge: applies inputs, advances the model, checks at the next falling edge.
  task automatic cyc(input int m, input int c, input bit cl, input string tag);
    int v;
    main_st  = 3'(m);
    cross_st = 3'(c);
    clr      = cl;
    if (!m_fault) begin
      v = expected_code(m, c);
      m_ml = 3'(m);
      m_cl = 3'(c);
      push_hist(m, c);
      if (v != 0) begin
        m_fault = 1'b1;
        m_code  = v;
        m_k     = 0;
      end
    end else if (cl) begin
      m_fault = 1'b0;
      m_code  = 0;
      m_ml    = 3'(m);
      m_cl    = 3'(c);
      hist_m.delete();
      hist_c.delete();
    end else begin
      m_k++;
      m_ml = ((((m_k - 1) / BLINK_HALF) % 2) == 0) ? 3'd4 : 3'd0;
      m_cl = m_ml;
      push_hist(m, c);
    end
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    chk_all(tag);
  endtask

  function automatic int next_legal(input int x);
    case (x)
      G:       return Y;
      Y:       return R;
      R:       return G;
      default: return R;
    endcase
  endfunction

  initial begin
    int cm, cc;
    model_reset();
    @(negedge clk);
    chk_all("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) cyc(G, R, 1'b0, "seq_green");
    for (int i = 0; i < 3; i++) cyc(Y, R, 1'b0, "seq_yellow");
    for (int i = 0; i < 2; i++) cyc(R, R, 1'b0, "seq_red");

    cyc(G, R, 1'b0, "short_g_g");
    cyc(G, R, 1'b0, "short_g_g");
    cyc(Y, R, 1'b0, "short_g_y");
    for (int i = 0; i < 6; i++) cyc(R, R, 1'b0, "short_g_flash");
    cyc(R, R, 1'b1, "clear1");

    cyc(G, G, 1'b0, "conflict");
    cyc(Y, R, 1'b0, "conflict_sticky_y");
    cyc(R, R, 1'b0, "conflict_sticky_r");
    cyc(R, R, 1'b1, "clear2");
    cyc(Y, R, 1'b0, "first_after_clear");
    cyc(Y, R, 1'b0, "first_after_clear");
    cyc(R, R, 1'b0, "first_after_clear");
    cyc(R, R, 1'b1, "clr_in_run");

    cyc(3, R, 1'b0, "illegal");
    for (int i = 0; i < 3; i++) cyc(R, R, 1'b0, "illegal_flash");

    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    cyc(R, R, 1'b0, "post_reset");
    cyc(Y, R, 1'b0, "bad_seq");
    cyc(R, R, 1'b0, "bad_seq_flash");
    cyc(R, R, 1'b1, "clear3");

    cm = R;
    cc = R;
    for (int n = 0; n < 600; n++) begin
      int r;
      bit cl;
      r = int'($urandom_range(0, 99));
      if (r >= 95) cm = int'($urandom_range(0, 7));
      else if (r >= 75) cm = next_legal(cm);
      r = int'($urandom_range(0, 99));
      if (r >= 97) cc = int'($urandom_range(0, 7));
      else if (r >= 80 && (cm == R || cc != R)) cc = next_legal(cc);
      cl = m_fault ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 29) == 0);
      cyc(cm, cc, cl, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
